// File: rtl/mouse_pos_sync.sv
// Frame-synchronous cursor position register: clamps raw mouse coordinates, buffers
// the latest sample and commits it at the start of vertical blanking, with idle auto-hide.
module mouse_pos_sync #(
   parameter int HOR_MAX     = 799,
   parameter int VER_MAX     = 599,
   parameter int HIDE_FRAMES = 120
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] mouse_xpos,
   input  logic [11:0] mouse_ypos,
   input  logic        mouse_valid,
   input  logic        vblnk,
   output logic [11:0] xpos_out,
   output logic [11:0] ypos_out,
   output logic        cursor_en,
   output logic        pos_update
);

   localparam logic [11:0] X_MAX    = 12'(HOR_MAX);
   localparam logic [11:0] Y_MAX    = 12'(VER_MAX);
   localparam logic [7:0]  HIDE_CNT = 8'(HIDE_FRAMES);

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } state_t;

   state_t      state;
   logic        vblnk_q;
   logic [11:0] bx;
   logic [11:0] by;
   logic [7:0]  idle_cnt;

   logic        vstart;
   logic [11:0] cx;
   logic [11:0] cy;
   logic        commit;
   logic [11:0] commit_x;
   logic [11:0] commit_y;
   logic        moved;
   logic [7:0]  idle_next;

   always_comb begin
      vstart = vblnk & ~vblnk_q;
      cx     = (mouse_xpos > X_MAX) ? X_MAX : mouse_xpos;
      cy     = (mouse_ypos > Y_MAX) ? Y_MAX : mouse_ypos;
   end

   // A fresh sample on the vstart cycle always beats the buffered one.
   always_comb begin
      commit    = vstart & (mouse_valid | (state == PENDING));
      commit_x  = mouse_valid ? cx : bx;
      commit_y  = mouse_valid ? cy : by;
      moved     = commit & ((commit_x != xpos_out) | (commit_y != ypos_out));
      idle_next = (idle_cnt >= HIDE_CNT) ? HIDE_CNT : idle_cnt + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         vblnk_q    <= 1'b0;
         bx         <= '0;
         by         <= '0;
         idle_cnt   <= '0;
         xpos_out   <= '0;
         ypos_out   <= '0;
         cursor_en  <= 1'b1;
         pos_update <= 1'b0;
      end else begin
         vblnk_q    <= vblnk;
         pos_update <= commit;

         case (state)
            IDLE: begin
               if (mouse_valid && !vstart) begin
                  bx    <= cx;
                  by    <= cy;
                  state <= PENDING;
               end
            end
            PENDING: begin
               if (vstart) begin
                  state <= IDLE;
               end else if (mouse_valid) begin
                  bx <= cx;
                  by <= cy;
               end
            end
            default: state <= IDLE;
         endcase

         if (commit) begin
            xpos_out <= commit_x;
            ypos_out <= commit_y;
         end

         // Idle tracking only advances once per frame; a no-move commit is still idle.
         if (vstart) begin
            if (moved) begin
               idle_cnt  <= '0;
               cursor_en <= 1'b1;
            end else begin
               idle_cnt <= idle_next;
               if ((HIDE_CNT != 8'd0) && (idle_next == HIDE_CNT))
                  cursor_en <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_mouse_pos_sync.sv
// Directed bench for mouse_pos_sync: one default instance and one with a short hide timeout,
// both driven from the same stimulus.
module tb_mouse_pos_sync;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] mouse_xpos;
   logic [11:0] mouse_ypos;
   logic        mouse_valid;
   logic        vblnk;

   logic [11:0] xpos_out, ypos_out;
   logic        cursor_en, pos_update;
   logic [11:0] h_xpos, h_ypos;
   logic        h_cursor_en, h_pos_update;

   int errors = 0;
   int checks = 0;
   int pulses = 0;

   always #5 clk = ~clk;

   mouse_pos_sync u_dut (
      .clk         (clk),
      .rst         (rst),
      .mouse_xpos  (mouse_xpos),
      .mouse_ypos  (mouse_ypos),
      .mouse_valid (mouse_valid),
      .vblnk       (vblnk),
      .xpos_out    (xpos_out),
      .ypos_out    (ypos_out),
      .cursor_en   (cursor_en),
      .pos_update  (pos_update)
   );

   mouse_pos_sync #(.HIDE_FRAMES(3)) u_hide (
      .clk         (clk),
      .rst         (rst),
      .mouse_xpos  (mouse_xpos),
      .mouse_ypos  (mouse_ypos),
      .mouse_valid (mouse_valid),
      .vblnk       (vblnk),
      .xpos_out    (h_xpos),
      .ypos_out    (h_ypos),
      .cursor_en   (h_cursor_en),
      .pos_update  (h_pos_update)
   );

   task automatic check(input string tag, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic send(input int x, input int y);
      mouse_valid = 1'b1;
      mouse_xpos  = 12'(x);
      mouse_ypos  = 12'(y);
      tick();
      mouse_valid = 1'b0;
   endtask

   // vblnk held high for several cycles; counts pos_update pulses seen.
   task automatic run_frame();
      pulses = 0;
      vblnk  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (pos_update) pulses++;
      end
      vblnk = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         if (pos_update) pulses++;
      end
   endtask

   initial begin
      rst         = 1'b1;
      mouse_xpos  = '0;
      mouse_ypos  = '0;
      mouse_valid = 1'b0;
      vblnk       = 1'b0;
      do_reset();

      check("rst_x", xpos_out, 0);
      check("rst_y", ypos_out, 0);
      check("rst_cen", cursor_en, 1);
      check("rst_pu", pos_update, 0);

      // Latency: sample, ten quiet cycles, then vstart.
      send(100, 50);
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (pos_update) pulses++;
      end
      check("wait_x", xpos_out, 0);
      check("wait_pulses", pulses, 0);
      vblnk = 1'b1;
      check("vstart_cycle_x", xpos_out, 0);
      tick();
      check("lat_x", xpos_out, 100);
      check("lat_y", ypos_out, 50);
      check("lat_pu", pos_update, 1);
      tick();
      check("lat_pu_low", pos_update, 0);
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (pos_update) pulses++;
      end
      check("hold_pulses", pulses, 0);
      vblnk = 1'b0;
      tick();

      // Clamp.
      send(900, 4095);
      run_frame();
      check("clamp_x", xpos_out, 799);
      check("clamp_y", ypos_out, 599);
      check("clamp_pulses", pulses, 1);
      send(799, 599);
      run_frame();
      check("edge_x", xpos_out, 799);
      check("edge_y", ypos_out, 599);
      check("edge_pulses", pulses, 1);

      // Last sample in a frame wins.
      send(10, 10);
      send(20, 20);
      send(30, 30);
      run_frame();
      check("last_x", xpos_out, 30);
      check("last_y", ypos_out, 30);
      check("last_pulses", pulses, 1);

      // Sample coincident with vstart overrides pending buffer.
      send(5, 5);
      check("pend_x", xpos_out, 30);
      mouse_valid = 1'b1;
      mouse_xpos  = 12'd40;
      mouse_ypos  = 12'd40;
      vblnk       = 1'b1;
      tick();
      mouse_valid = 1'b0;
      check("bypass_x", xpos_out, 40);
      check("bypass_y", ypos_out, 40);
      check("bypass_pu", pos_update, 1);
      for (int i = 0; i < 3; i++) tick();
      vblnk = 1'b0;
      tick();
      run_frame();
      check("after_bypass_pulses", pulses, 0);
      check("after_bypass_x", xpos_out, 40);

      // Hide timeout of 3 frames on the second instance.
      do_reset();
      check("h_rst_cen", h_cursor_en, 1);
      run_frame();
      check("h_f1_cen", h_cursor_en, 1);
      run_frame();
      check("h_f2_cen", h_cursor_en, 1);
      run_frame();
      check("h_f3_cen", h_cursor_en, 0);
      check("d_f3_cen", cursor_en, 1);
      send(1, 1);
      run_frame();
      check("h_move_cen", h_cursor_en, 1);
      check("h_move_x", h_xpos, 1);
      for (int i = 0; i < 3; i++) run_frame();
      check("h_rehide_cen", h_cursor_en, 0);
      send(1, 1);
      run_frame();
      check("h_same_cen", h_cursor_en, 0);
      check("h_same_pulses", pulses, 1);
      check("d_same_cen", cursor_en, 1);

      // Reset while pending drops the sample.
      send(200, 200);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      run_frame();
      check("rstpend_x", xpos_out, 0);
      check("rstpend_y", ypos_out, 0);
      check("rstpend_cen", cursor_en, 1);
      check("rstpend_pulses", pulses, 0);

      // vblnk already high as reset releases: first cycle is a vstart.
      send(300, 300);
      vblnk = 1'b1;
      rst   = 1'b1;
      tick();
      rst = 1'b0;
      send(7, 9);
      check("rstvb_x", xpos_out, 7);
      check("rstvb_y", ypos_out, 9);
      check("rstvb_pu", pos_update, 1);
      tick();
      check("rstvb_pu_low", pos_update, 0);
      vblnk = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
